vga_scan_timer: RTL and testbench

//  Generates 640x480@60 VGA raster timing from the board clock: pixel enable, pixel clock,

---
 rtl/vga_scan_timer_pkg.sv | 42 ++++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_scan_timer.sv | 131 +++++++++++++
 tb/tb_vga_scan_timer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_scan_timer_pkg.sv
// Shared VGA timing defaults, counter width and the captured-position record
// used by the scan timer and its downstream renderer/DAC stages.
package vga_scan_timer_pkg;

    localparam int   CNT_W           = 10;
    localparam int   MAX_TOTAL       = 1 << CNT_W;
    localparam logic SYNC_ACTIVE_LOW = 1'b0;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             hsync;
        logic             vsync;
        logic             blank_n;
    } scan_out_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Idle raster outputs: origin, syncs deasserted, blanked.
    function automatic scan_out_t idle_scan(input logic sync_pol);
        scan_out_t s;
        s.x       = '0;
        s.y       = '0;
        s.hsync   = ~sync_pol;
        s.vsync   = ~sync_pol;
        s.blank_n = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with sync-window and
// active-window decodes of the live count.
module vga_axis_counter
    import vga_scan_timer_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             wrap_in,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_out,
    output logic             sync_raw,
    output logic             active
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   SYNC_START = (CNT_W + 1)'(ACTIVE + FP);
    localparam logic [CNT_W:0]   SYNC_END   = (CNT_W + 1)'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W:0]   ACT_END    = (CNT_W + 1)'(ACTIVE);

    logic [CNT_W-1:0] cnt_q;
    logic             at_end;

    assign at_end   = (cnt_q == LAST);
    assign wrap_out = wrap_in && at_end;
    assign sync_raw = ({1'b0, cnt_q} >= SYNC_START) && ({1'b0, cnt_q} < SYNC_END);
    assign active   = ({1'b0, cnt_q} < ACT_END);
    assign cnt      = cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (en && wrap_in) begin
            cnt_q <= at_end ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_timer.sv
// 640x480@60 raster timing: pixel divider, h/v counters and registered,
// mutually aligned position/sync/blank/tick outputs.
module vga_scan_timer
    import vga_scan_timer_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clock,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic             vga_clk,
    output logic             pix_en,
    output logic             line_tick,
    output logic             frame_tick
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_scan_timer: H_TOTAL or V_TOTAL exceeds the counter range");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("vga_scan_timer: CLK_DIV must be even and at least 2");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync_raw;
    logic             v_sync_raw;
    logic             h_active;
    logic             v_active;
    logic             at_origin;
    scan_out_t        scan_q;

    assign pix_en   = (div_cnt == DIV_LAST);
    assign div_next = pix_en ? '0 : div_cnt + 1'b1;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clock    (clock),
        .reset    (reset),
        .en       (pix_en),
        .wrap_in  (1'b1),
        .cnt      (h_cnt),
        .wrap_out (h_wrap),
        .sync_raw (h_sync_raw),
        .active   (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clock    (clock),
        .reset    (reset),
        .en       (pix_en),
        .wrap_in  (h_wrap),
        .cnt      (v_cnt),
        .wrap_out (v_wrap),
        .sync_raw (v_sync_raw),
        .active   (v_active)
    );

    // vga_clk is registered from the next divider value so it always equals div_cnt >= CLK_DIV/2.
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            vga_clk <= (div_next >= DIV_HALF);
        end
    end

    // at_origin marks that the live counters sit on (0,0), so the capture knows a frame starts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_q     <= idle_scan(SYNC_POL);
            at_origin  <= 1'b1;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            if (pix_en) begin
                scan_q.x       <= h_cnt;
                scan_q.y       <= v_cnt;
                scan_q.hsync   <= h_sync_raw ? SYNC_POL : ~SYNC_POL;
                scan_q.vsync   <= v_sync_raw ? SYNC_POL : ~SYNC_POL;
                scan_q.blank_n <= h_active && v_active;
                line_tick      <= (h_cnt == '0);
                frame_tick     <= at_origin;
                at_origin      <= v_wrap;
            end
        end
    end

    assign x       = scan_q.x;
    assign y       = scan_q.y;
    assign hsync   = scan_q.hsync;
    assign vsync   = scan_q.vsync;
    assign blank_n = scan_q.blank_n;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: a default-timing instance and a shrunken CLK_DIV=4,
// active-high-sync instance, both checked every clock against a raster-index model.
module tb_vga_scan_timer;

    localparam int A_D = 2;
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;

    localparam int B_D = 4;
    localparam int B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 6,  B_VF = 1, B_VS = 2, B_VB = 1;
    localparam logic B_POL = 1'b1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic a_hsync, a_vsync, a_blank_n, a_vga_clk, a_pix_en, a_line_tick, a_frame_tick;
    logic b_hsync, b_vsync, b_blank_n, b_vga_clk, b_pix_en, b_line_tick, b_frame_tick;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    always #5 clock = ~clock;

    vga_scan_timer dut_a (
        .clock      (clock),
        .reset      (reset),
        .x          (a_x),
        .y          (a_y),
        .hsync      (a_hsync),
        .vsync      (a_vsync),
        .blank_n    (a_blank_n),
        .vga_clk    (a_vga_clk),
        .pix_en     (a_pix_en),
        .line_tick  (a_line_tick),
        .frame_tick (a_frame_tick)
    );

    vga_scan_timer #(
        .CLK_DIV (B_D),
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(B_POL)
    ) dut_b (
        .clock      (clock),
        .reset      (reset),
        .x          (b_x),
        .y          (b_y),
        .hsync      (b_hsync),
        .vsync      (b_vsync),
        .blank_n    (b_blank_n),
        .vga_clk    (b_vga_clk),
        .pix_en     (b_pix_en),
        .line_tick  (b_line_tick),
        .frame_tick (b_frame_tick)
    );

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (clocks since release=%0d)", tag, obs, exp, n);
        end
    endtask

    // Model: n clocks after release the divider phase is n%d and floor(n/d) pixels have been
    // captured; the most recent one is raster index (captures-1) in row-major order.
    task automatic check_dut(input string name, input int d,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic pol,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic ohs, input logic ovs, input logic obl,
                             input logic ovc, input logic ope, input logic olt, input logic oft);
        int ht, vt, ph, c, p, h, v;
        logic ehs, evs, ebl, elt, eft;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ph = n % d;
        c  = n / d;
        if (c == 0) begin
            h = 0; v = 0;
            ehs = ~pol; evs = ~pol; ebl = 1'b0; elt = 1'b0; eft = 1'b0;
        end else begin
            p   = (c - 1) % (ht * vt);
            h   = p % ht;
            v   = p / ht;
            ehs = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
            evs = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
            ebl = (h < ha) && (v < va);
            elt = (ph == 0) && (h == 0);
            eft = elt && (v == 0);
        end
        check_one({name, ".x"},          32'(ox),  32'(h));
        check_one({name, ".y"},          32'(oy),  32'(v));
        check_one({name, ".hsync"},      32'(ohs), 32'(ehs));
        check_one({name, ".vsync"},      32'(ovs), 32'(evs));
        check_one({name, ".blank_n"},    32'(obl), 32'(ebl));
        check_one({name, ".vga_clk"},    32'(ovc), 32'(ph >= d / 2));
        check_one({name, ".pix_en"},     32'(ope), 32'(ph == d - 1));
        check_one({name, ".line_tick"},  32'(olt), 32'(elt));
        check_one({name, ".frame_tick"}, 32'(oft), 32'(eft));
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) n = 0;
        else        n++;
        @(negedge clock);
        check_dut("a", A_D, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0,
                  a_x, a_y, a_hsync, a_vsync, a_blank_n, a_vga_clk, a_pix_en, a_line_tick, a_frame_tick);
        check_dut("b", B_D, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_POL,
                  b_x, b_y, b_hsync, b_vsync, b_blank_n, b_vga_clk, b_pix_en, b_line_tick, b_frame_tick);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int cnt;
        int b_frame;
        b_frame = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB) * B_D;

        // Held reset, then several lines of default timing and several small frames.
        reset = 1'b0;
        run(5);
        reset = 1'b1;
        run(6000);

        // Random-length runs interrupted by short mid-frame resets.
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(100, 2500));
            reset = 1'b0;
            run($urandom_range(1, 3));
            reset = 1'b1;
        end
        run(2500);

        // First frame_tick after release arrives CLK_DIV clocks later, then once per frame.
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (b_frame_tick !== 1'b1 && cnt < 2 * b_frame);
        check_one("b.first_frame_tick_delay", 32'(cnt), 32'(B_D));
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (b_frame_tick !== 1'b1 && cnt < 2 * b_frame);
        check_one("b.frame_tick_spacing", 32'(cnt), 32'(b_frame));

        // Default-timing line_tick period.
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (a_line_tick !== 1'b1 && cnt < 4000);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (a_line_tick !== 1'b1 && cnt < 4000);
        check_one("a.line_tick_spacing", 32'(cnt), 32'((A_HA + A_HF + A_HS + A_HB) * A_D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
